// File: rtl/dmem_access_ctrl.sv
// MEM-stage to single-port data SRAM sequencer: word stores and debug writes take 1 cycle; loads, sub-word stores (read-modify-write) and debug reads take 2.
// Stalls the pipe combinationally while an access is multi-cycle or while a starved debug request preempts it.
module dmem_access_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_LIM = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pm_re_i,
    input  logic              pm_we_i,
    input  logic [1:0]        pm_len_i,
    input  logic              pm_sign_i,
    input  logic [31:0]       pm_addr_i,
    input  logic [31:0]       pm_wdata_i,
    output logic [31:0]       pm_rdata_o,
    output logic              pm_stall_o,
    output logic              pm_misalign_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [31:0]       dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [31:0]       dbg_rdata_o,
    output logic              sram_en_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);
    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    typedef enum logic [2:0] {IDLE, P_RD, P_RMW, D_RD, D_PRE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;

    logic               pm_req, is_byte, is_half, is_word, misalign, starve_hit;
    logic [ADDR_W-1:0]  pm_waddr;
    logic [7:0]         byte_v;
    logic [15:0]        half_v;
    logic [31:0]        lane_data, merge_data;
    logic               dbg_issue, dbg_ack;
    logic               sram_en, sram_we, stall, mis;
    logic [ADDR_W-1:0]  sram_addr;
    logic [31:0]        sram_wdata, pm_rdata, dbg_rdata;
    logic               unused_addr_bits;

    assign pm_req     = pm_re_i | pm_we_i;
    assign is_half    = (pm_len_i == 2'b01);
    assign is_byte    = (pm_len_i == 2'b10);
    assign is_word    = !is_half && !is_byte;
    assign misalign   = (is_word && (pm_addr_i[1:0] != 2'b00)) || (is_half && pm_addr_i[0]);
    assign starve_hit = (starve_q == CNT_W'(STARVE_LIM));
    assign pm_waddr   = pm_addr_i[ADDR_W+1:2];
    assign unused_addr_bits = ^pm_addr_i[31:ADDR_W+2];

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        byte_v     = sram_rdata_i[{pm_addr_i[1:0], 3'b000} +: 8];
        half_v     = sram_rdata_i[{pm_addr_i[1], 4'b0000} +: 16];
        lane_data  = sram_rdata_i;
        merge_data = sram_rdata_i;
        if (is_byte) begin
            lane_data = {{24{pm_sign_i & byte_v[7]}}, byte_v};
            merge_data[{pm_addr_i[1:0], 3'b000} +: 8] = pm_wdata_i[7:0];
        end else if (is_half) begin
            lane_data = {{16{pm_sign_i & half_v[15]}}, half_v};
            merge_data[{pm_addr_i[1], 4'b0000} +: 16] = pm_wdata_i[15:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        dbg_issue  = 1'b0;
        dbg_ack    = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        stall      = 1'b0;
        mis        = 1'b0;
        pm_rdata   = '0;
        dbg_rdata  = '0;
        unique case (state_q)
            IDLE: begin
                // A starved debug request goes ahead of a waiting pipe access.
                if (dbg_req_i && (!pm_req || starve_hit)) begin
                    dbg_issue = 1'b1;
                    sram_en   = 1'b1;
                    sram_addr = dbg_addr_i;
                    stall     = pm_req;
                    if (dbg_we_i) begin
                        sram_we    = 1'b1;
                        sram_wdata = dbg_wdata_i;
                        dbg_ack    = 1'b1;
                        if (pm_req) begin
                            state_d = D_PRE;
                        end
                    end else begin
                        state_d = D_RD;
                    end
                end else if (pm_req) begin
                    if (misalign) begin
                        mis = 1'b1;
                    end else begin
                        sram_en   = 1'b1;
                        sram_addr = pm_waddr;
                        if (pm_we_i && is_word) begin
                            sram_we    = 1'b1;
                            sram_wdata = pm_wdata_i;
                        end else begin
                            stall   = 1'b1;
                            state_d = pm_we_i ? P_RMW : P_RD;
                        end
                    end
                end
            end
            P_RD: begin
                pm_rdata = lane_data;
                state_d  = IDLE;
            end
            P_RMW: begin
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = pm_waddr;
                sram_wdata = merge_data;
                state_d    = IDLE;
            end
            D_RD: begin
                dbg_rdata = sram_rdata_i;
                dbg_ack   = 1'b1;
                stall     = pm_req;
                state_d   = IDLE;
            end
            D_PRE: begin
                stall   = pm_req;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (dbg_ack) begin
            starve_d = '0;
        end else if (dbg_req_i && !dbg_issue && !starve_hit) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Outputs are forced low while reset is held so an aborted access cannot write.
    assign sram_en_o     = rst & sram_en;
    assign sram_we_o     = rst & sram_we;
    assign sram_addr_o   = rst ? sram_addr : '0;
    assign sram_wdata_o  = rst ? sram_wdata : '0;
    assign pm_stall_o    = rst & stall;
    assign pm_misalign_o = rst & mis;
    assign pm_rdata_o    = rst ? pm_rdata : '0;
    assign dbg_ack_o     = rst & dbg_ack;
    assign dbg_rdata_o   = rst ? dbg_rdata : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural synchronous SRAM.
module tb_dmem_access_ctrl;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              pm_re_i, pm_we_i, pm_sign_i;
    logic [1:0]        pm_len_i;
    logic [31:0]       pm_addr_i, pm_wdata_i, pm_rdata_o;
    logic              pm_stall_o, pm_misalign_o;
    logic              dbg_req_i, dbg_we_i, dbg_ack_o;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [31:0]       dbg_wdata_i, dbg_rdata_o;
    logic              sram_en_o, sram_we_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [31:0]       sram_wdata_o;
    logic [31:0]       sram_rdata_i = 32'h0;

    logic [31:0] mem [0:1023];
    int n_chk = 0, n_err = 0;
    int n_wr = 0, n_rd = 0, n_ack = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ADDR_W(ADDR_W), .STARVE_LIM(16)) dut (
        .clk(clk), .rst(rst),
        .pm_re_i(pm_re_i), .pm_we_i(pm_we_i), .pm_len_i(pm_len_i), .pm_sign_i(pm_sign_i),
        .pm_addr_i(pm_addr_i), .pm_wdata_i(pm_wdata_i), .pm_rdata_o(pm_rdata_o),
        .pm_stall_o(pm_stall_o), .pm_misalign_o(pm_misalign_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
        .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
    );

    always @(posedge clk) begin
        if (sram_en_o) begin
            if (sram_we_o) begin
                mem[sram_addr_o] <= sram_wdata_o;
                n_wr++;
            end else begin
                sram_rdata_i <= mem[sram_addr_o];
                n_rd++;
            end
        end
        if (dbg_ack_o) n_ack++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic clear_pm();
        pm_re_i = 1'b0; pm_we_i = 1'b0; pm_len_i = 2'b00; pm_sign_i = 1'b0;
        pm_addr_i = 32'h0; pm_wdata_i = 32'h0;
    endtask

    // Called just after a rising edge; holds the request until stall drops.
    task automatic pm_access(input logic we, input logic re, input logic [1:0] len, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd, output int stalls, output logic mis);
        pm_we_i = we; pm_re_i = re; pm_len_i = len; pm_sign_i = sgn;
        pm_addr_i = addr; pm_wdata_i = wd;
        stalls = 0;
        @(negedge clk);
        while (pm_stall_o && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        rd  = pm_rdata_o;
        mis = pm_misalign_o;
        @(posedge clk); #1;
        clear_pm();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, dgot;
        logic        mis;
        int          st, w0, r0, a0, li, cyc, scnt, ack_cyc;

        rst = 1'b0;
        clear_pm();
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = 32'h0;
        pm_we_i = 1'b1; pm_addr_i = 32'h40; pm_wdata_i = 32'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sram_en", 32'(sram_en_o), 32'd0);
        check("rst_sram_we", 32'(sram_we_o), 32'd0);
        check("rst_stall", 32'(pm_stall_o), 32'd0);
        check("rst_ack", 32'(dbg_ack_o), 32'd0);
        check("rst_pm_rdata", pm_rdata_o, 32'h0);
        @(posedge clk); #1;
        clear_pm();
        rst = 1'b1;
        @(posedge clk); #1;

        // Word store then word load
        w0 = n_wr;
        pm_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'hDEADBEEF, rd, st, mis);
        check("wst_stall", 32'(st), 32'd0);
        check("wst_nwr", 32'(n_wr - w0), 32'd1);
        check("wst_mem", mem[10'h010], 32'hDEADBEEF);
        pm_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h40, 32'h0, rd, st, mis);
        check("wld_stall", 32'(st), 32'd1);
        check("wld_data", rd, 32'hDEADBEEF);
        check("wld_mis", 32'(mis), 32'd0);

        // Byte store by read-modify-write, then byte loads
        pm_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h11223344, rd, st, mis);
        w0 = n_wr; r0 = n_rd;
        pm_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h42, 32'h000000AB, rd, st, mis);
        check("bst_stall", 32'(st), 32'd1);
        check("bst_mem", mem[10'h010], 32'h11AB3344);
        check("bst_nrd", 32'(n_rd - r0), 32'd1);
        check("bst_nwr", 32'(n_wr - w0), 32'd1);
        pm_access(1'b0, 1'b1, 2'b10, 1'b1, 32'h42, 32'h0, rd, st, mis);
        check("bld_signed", rd, 32'hFFFFFFAB);
        pm_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h42, 32'h0, rd, st, mis);
        check("bld_unsigned", rd, 32'h000000AB);

        // Halfword store and loads
        pm_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h42, 32'h00008001, rd, st, mis);
        check("hst_stall", 32'(st), 32'd1);
        check("hst_mem", mem[10'h010], 32'h80013344);
        pm_access(1'b0, 1'b1, 2'b01, 1'b1, 32'h42, 32'h0, rd, st, mis);
        check("hld_signed_hi", rd, 32'hFFFF8001);
        pm_access(1'b0, 1'b1, 2'b01, 1'b1, 32'h40, 32'h0, rd, st, mis);
        check("hld_signed_lo", rd, 32'h00003344);
        pm_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, rd, st, mis);
        check("bld_lane0", rd, 32'h00000044);
        pm_access(1'b0, 1'b1, 2'b11, 1'b1, 32'h40, 32'h0, rd, st, mis);
        check("len11_word", rd, 32'h80013344);

        // Misaligned accesses
        w0 = n_wr; r0 = n_rd;
        pm_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h41, 32'h0, rd, st, mis);
        check("mis_wld_pulse", 32'(mis), 32'd1);
        check("mis_wld_stall", 32'(st), 32'd0);
        check("mis_wld_data", rd, 32'h0);
        pm_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h43, 32'h0000FFFF, rd, st, mis);
        check("mis_hst_pulse", 32'(mis), 32'd1);
        check("mis_hst_stall", 32'(st), 32'd0);
        check("mis_no_access", 32'((n_wr - w0) + (n_rd - r0)), 32'd0);
        check("mis_mem", mem[10'h010], 32'h80013344);

        // Debug write and read with the pipe idle
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 10'h020; dbg_wdata_i = 32'hCAFEF00D;
        @(negedge clk);
        check("dwr_ack", 32'(dbg_ack_o), 32'd1);
        check("dwr_stall", 32'(pm_stall_o), 32'd0);
        @(posedge clk); #1;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0;
        check("dwr_mem", mem[10'h020], 32'hCAFEF00D);
        dbg_req_i = 1'b1;
        @(negedge clk);
        check("drd_ack_early", 32'(dbg_ack_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("drd_ack", 32'(dbg_ack_o), 32'd1);
        check("drd_data", dbg_rdata_o, 32'hCAFEF00D);
        @(posedge clk); #1;
        dbg_req_i = 1'b0;
        @(negedge clk);
        check("drd_data_idle", dbg_rdata_o, 32'h0);
        @(posedge clk); #1;

        // Starvation preempt: debug read against back-to-back pipe loads
        for (int i = 0; i < 8; i++)
            pm_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i), rd, st, mis);
        r0 = n_rd; w0 = n_wr; a0 = n_ack;
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 10'h010;
        ack_cyc = -1; dgot = 32'h0; li = 0; cyc = 0; scnt = 0;
        while (li < 10 && cyc < 100) begin
            pm_re_i = 1'b1; pm_len_i = 2'b00; pm_sign_i = 1'b0;
            pm_addr_i = 32'h100 + 32'(4 * (li % 8));
            @(negedge clk);
            if (dbg_ack_o) begin
                ack_cyc = cyc;
                dgot = dbg_rdata_o;
            end
            if (pm_stall_o) begin
                scnt++;
            end else begin
                check($sformatf("stv_ld%0d_data", li), pm_rdata_o, 32'hA0000000 + 32'(li % 8));
                check($sformatf("stv_ld%0d_stall", li), 32'(scnt), (li == 8) ? 32'd3 : 32'd1);
                li++;
                scnt = 0;
            end
            @(posedge clk); #1;
            cyc++;
            if (ack_cyc >= 0) dbg_req_i = 1'b0;
        end
        clear_pm();
        dbg_req_i = 1'b0;
        check("stv_loads_done", 32'(li), 32'd10);
        check("stv_ack_cycle", 32'(ack_cyc), 32'd17);
        check("stv_dbg_data", dgot, 32'h80013344);
        check("stv_nrd", 32'(n_rd - r0), 32'd11);
        check("stv_nwr", 32'(n_wr - w0), 32'd0);
        check("stv_nack", 32'(n_ack - a0), 32'd1);
        @(posedge clk); #1;

        // Reset dropped during the merge-write cycle
        w0 = n_wr;
        pm_we_i = 1'b1; pm_len_i = 2'b10; pm_addr_i = 32'h40; pm_wdata_i = 32'h00000055;
        @(negedge clk);
        check("rrmw_read_stall", 32'(pm_stall_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rrmw_sram_en", 32'(sram_en_o), 32'd0);
        check("rrmw_sram_we", 32'(sram_we_o), 32'd0);
        check("rrmw_stall", 32'(pm_stall_o), 32'd0);
        check("rrmw_wdata", sram_wdata_o, 32'h0);
        @(posedge clk); #1;
        clear_pm();
        @(posedge clk); #1;
        rst = 1'b1;
        check("rrmw_nwr", 32'(n_wr - w0), 32'd0);
        check("rrmw_mem", mem[10'h010], 32'h80013344);
        pm_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h40, 32'h0, rd, st, mis);
        check("rrmw_reload_stall", 32'(st), 32'd1);
        check("rrmw_reload_data", rd, 32'h80013344);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequencer and arbiter between the MEM pipeline stage and a single-port, word-wide synchronous data SRAM; a debug/loader port shares the same SRAM.
- Performs sub-word loads by lane extraction and sub-word stores by read-modify-write (RMW).
- Holds the pipeline through `pm_stall_o` while a multi-cycle access is in progress.
- Sits between the MEM-stage control signals (memwe, memlen, ALU address, rd2 store data) and the SRAM macro.

Parameters:
- ADDR_W, 10, SRAM word-address width; byte address uses bits [ADDR_W+1:0].
- STARVE_LIM, 16, consecutive cycles a pending debug request may wait before it preempts the pipeline.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- pm_re_i  in  1  MEM-stage load request.
- pm_we_i  in  1  MEM-stage store request.
- pm_len_i  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- pm_sign_i  in  1  1 = sign-extend sub-word load data; 0 = zero-extend.
- pm_addr_i  in  32  byte address (ALU output).
- pm_wdata_i  in  32  store data, right-aligned.
- pm_rdata_o  out  32  load result; valid in the cycle `pm_stall_o` drops.
- pm_stall_o  out  1  pipeline hold (combinational).
- pm_misalign_o  out  1  one-cycle pulse when an access is misaligned.
- dbg_req_i  in  1  debug request; held until acknowledged.
- dbg_we_i  in  1  debug write (word only).
- dbg_addr_i  in  ADDR_W  debug word address.
- dbg_wdata_i  in  32  debug write data.
- dbg_ack_o  out  1  one-cycle completion pulse.
- dbg_rdata_o  out  32  debug read data; valid with `dbg_ack_o`.
- sram_en_o  out  1  SRAM access enable.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  ADDR_W  SRAM word address.
- sram_wdata_o  out  32  SRAM write data.
- sram_rdata_i  in  32  SRAM read data; valid the cycle after a read with en=1, we=0.

Behaviour:
- **Reset state:** state IDLE; starve counter 0; all outputs 0; `pm_stall_o` 0. Reset asserted mid-access aborts it: no SRAM write is issued and no ack is generated.
- **States:** IDLE, P_RD (pipe load data return), P_RMW (sub-word merge write), D_RD (debug read return), D_PRE (debug preempt).
- **Pipe request:** pm_req = `pm_re_i | pm_we_i`. If both are high, the access is a store.
- **Misalignment:** word access with `addr[1:0] != 0`, or halfword access with `addr[0] == 1`.
  - `pm_misalign_o` pulses for one cycle.
  - No SRAM access is made; `pm_stall_o` stays 0; `pm_rdata_o` = 0.
- **IDLE, aligned word store:** SRAM write (en=1, we=1, addr = `addr[ADDR_W+1:2]`) in the same cycle. Stall 0. Latency 1.
- **IDLE, load:** SRAM read issued; stall 1; next state P_RD.
- **P_RD:**
  - Lane select: byte lane = `addr[1:0]`, halfword lane = `addr[1]`.
  - Result is sign- or zero-extended per `pm_sign_i` and driven on `pm_rdata_o`.
  - Stall 0; next state IDLE.
  - Pipeline holds all `pm_*` inputs stable while stall is 1.
- **IDLE, sub-word store:** SRAM read; stall 1; next state P_RMW.
- **P_RMW:**
  - Write `sram_rdata_i` with the selected lane replaced by the low 8 or 16 bits of `pm_wdata_i`; other lanes unchanged.
  - Stall 0; next state IDLE.
- **Debug in IDLE:** served only when there is no pipe request, or when starve count equals STARVE_LIM.
  - Write: 1 cycle; `dbg_ack_o` pulses in the same cycle.
  - Read: go to D_RD; next cycle `dbg_rdata_o` = `sram_rdata_i` and `dbg_ack_o` = 1.
- **Starvation counter:**
  - Increments each cycle `dbg_req_i` is high and debug is not served.
  - Saturates at STARVE_LIM.
  - Clears when the debug request is acknowledged.
- **Preempt:** when starve count equals STARVE_LIM and a pipe request is present:
  - Debug access is served first; `pm_stall_o` = 1 for its full duration (D_PRE covers the write case for uniform stall timing).
  - The pipe access starts on return to IDLE.
- **Priority:** pipe over debug, except during preempt. At most one SRAM access per cycle.
- **Outputs when idle:** SRAM outputs are 0 when not accessing. `pm_rdata_o` and `dbg_rdata_o` are 0 outside their valid cycles.

Test Plan:
- **Word store/load:** store 0xDEADBEEF at 0x40, then word load at 0x40 → one SRAM write to word 0x10; load stalls exactly 1 cycle; `pm_rdata_o` = 0xDEADBEEF.
- **Byte store RMW:** word 0x11223344 at 0x40; byte store 0xAB at 0x42 → read then write of 0x11AB3344; stall 1 cycle. Then signed byte load at 0x42 → 0xFFFFFFAB; unsigned → 0x000000AB.
- **Halfword store/load:** halfword store 0x8001 at 0x42 → word becomes 0x80013344. Signed halfword load at 0x42 → 0xFFFF8001.
- **Misaligned accesses:** word load at 0x41 and halfword store at 0x43 → `pm_misalign_o` pulses; no `sram_en_o`; stall 0; memory unchanged.
- **Starvation preempt:** debug read requested while pipe issues back-to-back loads for 20 cycles, STARVE_LIM=16 → debug acked with correct data during preemption; pipe stalled for the preempt; no pipe access lost or duplicated.
- **Reset mid-RMW:** drop `rst` during P_RMW → no SRAM write; all outputs 0; target word unchanged after reset release.
